title_menu_ctrl: RTL and testbench
==================================

Name: title_menu_ctrl

Overview:
- Control stage directly upstream of the title screen renderer. Debounces the front-panel buttons and runs the title/menu state machine.
- Produces the frame-synchronous playerCount select consumed by the title screen overlay, a blink strobe for the selected-option highlight, and a one-cycle game_start pulse to the game core.
- Returns to the title when the game core reports game_over.

Parameters:
- DEBOUNCE_CYCLES, 650000, pclk cycles a raw button must stay stable before its debounced level changes (10 ms at 65 MHz).
- BLINK_FRAMES, 30, frames per blink half-period.
- START_DELAY_FRAMES, 60, frames between start press and game_start pulse (title hold / fade).

Ports:
- pclk  in  1  pixel clock, sole clock domain.
- rst  in  1  synchronous active-high reset.
- btn_up  in  1  raw, asynchronous; selects 1 player.
- btn_down  in  1  raw, asynchronous; selects 2 players.
- btn_start  in  1  raw, asynchronous; confirm.
- vsync  in  1  vsync from the VGA bus, active high.
- game_over  in  1  level from game core; requests return to title.
- playerCount  out  1  0 = one player, 1 = two players; changes only at a frame start.
- title_active  out  1  1 while the title screen is to be displayed.
- blink  out  1  highlight blink phase.
- game_start  out  1  single-cycle pulse to launch the game.

Behaviour:
- Reset (synchronous, rst=1 on a pclk edge):
  - playerCount=0, title_active=1, blink=0, game_start=0.
  - State TITLE; all counters cleared; debounced levels 0.
  - A reset asserted mid-operation (e.g. during STARTING) aborts to this state on the next edge.
- Input synchroniser: each button passes a 2-flop synchroniser first.
- Debounce:
  - Per button, a counter runs while the synchronised input differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the input value and the counter clears.
  - Rising-edge detect on the debounced level gives a one-cycle press event.
- Total latency from a stable raw edge to the press event: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Frame start: vsync rising edge, registered, giving a one-cycle frame_tick.
- FSM states TITLE, STARTING, GAME:
  - TITLE, up press: pending_sel=0.
  - TITLE, down press: pending_sel=1.
  - TITLE, up and down press in the same cycle: pending_sel unchanged.
  - TITLE, start press: go to STARTING; the frame counter clears.
  - TITLE, start press in the same cycle as up/down: the selection press is applied first, then STARTING.
  - STARTING: buttons ignored. On each frame_tick the frame counter increments. On the tick where it reaches START_DELAY_FRAMES-1: game_start=1 for that cycle (registered, visible the next cycle), then go to GAME.
  - GAME: title_active=0, blink=0, buttons ignored.
  - GAME with game_over=1: go to TITLE; pending_sel and playerCount are retained; the blink counter clears.
  - game_over while in TITLE or STARTING: ignored.
- playerCount <= pending_sel only on frame_tick, so the renderer never tears mid-frame. playerCount is frozen outside TITLE.
- Blink (TITLE only):
  - The frame counter counts frame_ticks 0..BLINK_FRAMES-1 and wraps; blink toggles on each wrap.
  - In STARTING, blink is held at 1 (solid highlight).
- title_active: 1 in TITLE and STARTING, 0 in GAME. Registered; changes on the cycle after the state change.
- All outputs are registered; no combinational path from any input to any output.
- Counter widths are sized with $clog2 of the parameter.

Decomposition:
- Shared header (next to the VGA bus macros): state encodings TITLE=2'd0, STARTING=2'd1, GAME=2'd2; PLAYERS_1=1'b0, PLAYERS_2=1'b1.
- One natural sub-module: btn_debounce (synchroniser + counter + rising-edge press output, parameter DEBOUNCE_CYCLES), instantiated three times.
- FSM, frame tick and blink logic stay in title_menu_ctrl.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, START_DELAY_FRAMES=3 and vsync period 50 cycles.
- Reset: hold rst for 3 cycles with buttons toggling -> playerCount=0, title_active=1, blink=0, game_start=0 throughout and after release.
- Debounce: glitch btn_down for 3 cycles -> playerCount stays 0. Hold btn_down for 10 cycles -> playerCount=1 exactly on the next frame_tick, not before.
- Selection at frame boundary: press down mid-frame -> playerCount goes 0->1 only at the next vsync rise. Press up and down together -> no change.
- Blink: in TITLE, blink toggles every 2 frame_ticks (period 4 frames); playerCount is unaffected.
- Start sequence: press start with playerCount=1 -> blink=1 solid, single game_start pulse on the 3rd frame_tick. title_active=0 on the following cycle; further presses ignored; playerCount stays 1.
- Return and abort:
  - game_over=1 in GAME -> title_active=1 next cycle, playerCount still 1.
  - rst asserted during STARTING -> no game_start pulse, state TITLE, playerCount=0.

Source files
------------

// File: rtl/title_menu_ctrl_pkg.sv
// Shared encodings for the title/menu control stage.
package title_menu_ctrl_pkg;

  typedef enum logic [1:0] {
    TITLE    = 2'd0,
    STARTING = 2'd1,
    GAME     = 2'd2
  } menu_state_t;

  localparam logic PLAYERS_1 = 1'b0;
  localparam logic PLAYERS_2 = 1'b1;

  // Button slot order inside the debouncer instance array.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_START = 2;
  localparam int NUM_BTNS  = 3;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/title_menu_ctrl_btn_debounce.sv
// Per-button 2-flop synchroniser, stability counter and rising-edge press.
module btn_debounce
  import title_menu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl;
  logic          lvl_q;

  // Synchronise, then adopt the new level only after it held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      lvl_q <= lvl;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Internal one-cycle event; the top registers everything it drives out.
  assign press = lvl & ~lvl_q;

endmodule

// File: rtl/title_menu_ctrl.sv
// Title/menu controller: debounced buttons, frame tick, menu FSM and blink.
module title_menu_ctrl
  import title_menu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 650000,
  parameter int BLINK_FRAMES       = 30,
  parameter int START_DELAY_FRAMES = 60
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_start,
  input  logic vsync,
  input  logic game_over,
  output logic playerCount,
  output logic title_active,
  output logic blink,
  output logic game_start
);

  localparam int FRAMES_MAX = (BLINK_FRAMES > START_DELAY_FRAMES) ? BLINK_FRAMES : START_DELAY_FRAMES;
  localparam int FW = cnt_w(FRAMES_MAX);
  localparam logic [FW-1:0] BLINK_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] START_MAX = FW'(START_DELAY_FRAMES - 1);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] press;
  logic                up, down, start;

  assign raw   = {btn_start, btn_down, btn_up};
  assign up    = press[BTN_UP];
  assign down  = press[BTN_DOWN];
  assign start = press[BTN_START];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTNS-1:0] (
    .clk   (pclk),
    .rst   (rst),
    .btn   (raw),
    .press (press)
  );

  logic vs_q;
  logic frame_tick;

  // Registered vsync rising edge marks the start of each frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync;
      frame_tick <= vsync & ~vs_q;
    end
  end

  menu_state_t   state;
  logic          pending_sel;
  logic [FW-1:0] fcnt;

  // Menu FSM; fcnt is the blink counter in TITLE and the start delay in STARTING.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= TITLE;
      pending_sel  <= PLAYERS_1;
      playerCount  <= PLAYERS_1;
      title_active <= 1'b1;
      blink        <= 1'b0;
      game_start   <= 1'b0;
      fcnt         <= '0;
    end else begin
      game_start   <= 1'b0;
      title_active <= (state != GAME);
      case (state)
        TITLE: begin
          if (up && !down)      pending_sel <= PLAYERS_1;
          else if (down && !up) pending_sel <= PLAYERS_2;
          // Selection only reaches the renderer at a frame boundary.
          if (frame_tick) begin
            playerCount <= pending_sel;
            if (fcnt == BLINK_MAX) begin
              fcnt  <= '0;
              blink <= ~blink;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
          if (start) begin
            state <= STARTING;
            fcnt  <= '0;
            blink <= 1'b1;
          end
        end
        STARTING: begin
          blink <= 1'b1;
          if (frame_tick) begin
            if (fcnt == START_MAX) begin
              game_start <= 1'b1;
              state      <= GAME;
              fcnt       <= '0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        GAME: begin
          blink <= 1'b0;
          if (game_over) begin
            state <= TITLE;
            fcnt  <= '0;
          end
        end
        default: state <= TITLE;
      endcase
    end
  end

endmodule

// File: tb/tb_title_menu_ctrl.sv
// Directed bench for title_menu_ctrl with short debounce and frame timings.
module tb_title_menu_ctrl;

  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic vsync = 1'b0, game_over = 1'b0;
  logic playerCount, title_active, blink, game_start;

  int checks = 0;
  int errors = 0;
  int vcnt   = 10;
  int nrise  = 0;
  int gs_cnt = 0;

  title_menu_ctrl #(
    .DEBOUNCE_CYCLES(4), .BLINK_FRAMES(2), .START_DELAY_FRAMES(3)
  ) dut (
    .pclk(pclk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .vsync(vsync), .game_over(game_over),
    .playerCount(playerCount), .title_active(title_active),
    .blink(blink), .game_start(game_start)
  );

  always #5 pclk = ~pclk;

  // 50-cycle frame, vsync high for 5 cycles, first rise well after reset release.
  always @(negedge pclk) begin
    vcnt  = (vcnt + 1) % 50;
    vsync = (vcnt < 5);
  end

  always @(posedge vsync) if (!rst) nrise++;
  always @(posedge pclk) if (game_start === 1'b1) gs_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Returns just after the DUT has consumed the frame tick of the next vsync rise.
  task automatic wait_frame();
    @(posedge vsync);
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      btn_up = i[0]; btn_down = ~i[0]; btn_start = i[1];
      tick(1);
      chk("rst_pc", playerCount, 0);
      chk("rst_ta", title_active, 1);
      chk("rst_blink", blink, 0);
      chk("rst_gs", game_start, 0);
    end
    btn_up = 0; btn_down = 0; btn_start = 0; rst = 0;
    tick(1);
    chk("rel_pc", playerCount, 0);
    chk("rel_ta", title_active, 1);
    chk("rel_blink", blink, 0);
    chk("rel_gs", game_start, 0);

    // 3-cycle glitch must not register
    wait_frame();
    btn_down = 1; tick(3); btn_down = 0;
    wait_frame(); wait_frame();
    chk("glitch_pc", playerCount, 0);

    // held press applies exactly at the next frame tick
    wait_frame();
    btn_down = 1; tick(10); btn_down = 0;
    chk("sel_midframe", playerCount, 0);
    @(posedge vsync);
    tick(1);
    chk("sel_pre_tick", playerCount, 0);
    tick(1);
    chk("sel_on_tick", playerCount, 1);

    tick(10);
    btn_up = 1; tick(10); btn_up = 0;
    wait_frame();
    chk("sel_up", playerCount, 0);
    tick(5);
    btn_down = 1; tick(10); btn_down = 0;
    wait_frame();
    chk("sel_down", playerCount, 1);
    tick(5);
    btn_up = 1; btn_down = 1; tick(10); btn_up = 0; btn_down = 0;
    wait_frame(); wait_frame();
    chk("sel_both", playerCount, 1);

    // blink phase follows frame ticks counted since reset
    for (int f = 0; f < 4; f++) begin
      wait_frame();
      chk("blink_phase", blink, (nrise / 2) % 2);
      chk("blink_pc", playerCount, 1);
    end

    // start sequence with presses ignored while starting
    wait_frame();
    btn_start = 1; tick(10); btn_start = 0;
    chk("start_blink", blink, 1);
    chk("start_ta", title_active, 1);
    btn_up = 1; tick(10); btn_up = 0;
    wait_frame();
    chk("st_tick1_gs", gs_cnt, 0);
    chk("st_tick1_blink", blink, 1);
    wait_frame();
    chk("st_tick2_gs", gs_cnt, 0);
    wait_frame();
    chk("gs_pulse", game_start, 1);
    tick(1);
    chk("gs_single", game_start, 0);
    chk("ta_game", title_active, 0);
    chk("game_blink", blink, 0);
    chk("game_pc", playerCount, 1);

    btn_up = 1; btn_start = 1; tick(10); btn_up = 0; btn_start = 0;
    wait_frame();
    chk("game_ignore_ta", title_active, 0);
    chk("game_ignore_pc", playerCount, 1);
    chk("gs_count", gs_cnt, 1);

    // return to title keeps the selection
    game_over = 1; tick(1); game_over = 0;
    tick(1);
    chk("ret_ta", title_active, 1);
    chk("ret_pc", playerCount, 1);
    wait_frame();
    chk("ret_pc_frame", playerCount, 1);

    game_over = 1; tick(5); game_over = 0;
    chk("go_title_ta", title_active, 1);

    // reset while starting aborts the launch
    wait_frame();
    btn_start = 1; tick(10); btn_start = 0;
    chk("abort_starting", blink, 1);
    wait_frame();
    rst = 1; tick(2); rst = 0;
    tick(1);
    chk("abort_pc", playerCount, 0);
    chk("abort_ta", title_active, 1);
    chk("abort_blink", blink, 0);
    chk("abort_gs", game_start, 0);
    wait_frame(); wait_frame(); wait_frame();
    chk("abort_no_pulse", gs_cnt, 1);
    chk("abort_title", title_active, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
